// File: rtl/tm_slave_multimaster_rb_pkg.sv
// Shared types and widths for the slave-side traffic-manager shell.
// Optional build macro used by the top: TM_SLAVE_RSP_SKID_EN.
package tm_slave_pkg;

   localparam int TSR_WIDTH_TAG       = 8;
   localparam int TSR_WIDTH_DATA_OUT  = 36;
   localparam int TSR_MAX_OUTSTANDING = 8;
   localparam int CNT_W               = $clog2(TSR_MAX_OUTSTANDING) + 1;

   typedef logic [TSR_WIDTH_TAG-1:0] tag_t;

   typedef struct packed {
      tag_t                          tag;
      logic [TSR_WIDTH_DATA_OUT-1:0] data;
   } rsp_entry_t;

endpackage

// File: rtl/tm_slave_multimaster_rb_tag_fifo.sv
// Show-ahead synchronous FIFO holding request tags in arrival order.
// Binary pointers carry one extra bit so full and empty are distinguishable.
module tag_fifo_tsr #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     preset_full,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         din,
   output logic [WIDTH-1:0]         head,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = 1;

   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic [WIDTH-1:0] mem [DEPTH];

   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign count = wr_ptr - rd_ptr;
   assign head  = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk or posedge preset_full) begin
      if (preset_full) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push && !full)  wr_ptr <= wr_ptr + PTR_ONE;
         if (pop && !empty)  rd_ptr <= rd_ptr + PTR_ONE;
      end
   end

   // Storage needs no reset; only the pointers define validity.
   always_ff @(posedge clk) begin
      if (push && !full) mem[wr_ptr[AW-1:0]] <= din;
   end

endmodule

// File: rtl/tm_slave_multimaster_rb.sv
// Slave-side TM shell: tags requests in order, re-attaches them to responses, returns credits.
// Build macro TM_SLAVE_RSP_SKID_EN selects a 2-entry skid output stage.
module tm_slave_multimaster_rb
   import tm_slave_pkg::*;
#(
   parameter int WIDTH_DATA_IN   = 36,
   parameter int WIDTH_DATA_OUT  = 36,
   parameter int WIDTH_TAG       = 8,
   parameter int MAX_OUTSTANDING = 8
) (
   input  logic                                 clk,
   input  logic                                 preset_full,
   input  logic                                 req_valid_in,
   output logic                                 req_ready_out,
   input  logic [WIDTH_TAG-1:0]                 req_tag_in,
   input  logic [WIDTH_DATA_IN-1:0]             req_data_in,
   output logic                                 req_valid_out,
   input  logic                                 req_ready_in,
   output logic [WIDTH_DATA_IN-1:0]             req_data_out,
   input  logic                                 rsp_valid_in,
   output logic                                 rsp_ready_out,
   input  logic [WIDTH_DATA_OUT-1:0]            rsp_data_in,
   output logic                                 rsp_valid_out,
   input  logic                                 rsp_ready_in,
   output logic [WIDTH_TAG-1:0]                 rsp_tag_out,
   output logic [WIDTH_DATA_OUT-1:0]            rsp_data_out,
   output logic                                 credit_return_out,
   output logic [$clog2(MAX_OUTSTANDING):0]     outstanding_out,
   output logic                                 err_orphan_out
);

   logic                 tag_full;
   logic                 tag_empty;
   logic [WIDTH_TAG-1:0] tag_head;
   logic                 push;
   logic                 pop;
   logic                 depart;

   assign req_valid_out = req_valid_in & ~tag_full;
   assign req_ready_out = req_ready_in & ~tag_full;
   assign req_data_out  = req_data_in;
   assign push          = req_valid_in & req_ready_out;
   assign pop           = rsp_valid_in & rsp_ready_out;
   assign depart        = rsp_valid_out & rsp_ready_in;

   tag_fifo_tsr #(
      .WIDTH (WIDTH_TAG),
      .DEPTH (MAX_OUTSTANDING)
   ) u_tags (
      .clk         (clk),
      .preset_full (preset_full),
      .push        (push),
      .pop         (pop),
      .din         (req_tag_in),
      .head        (tag_head),
      .full        (tag_full),
      .empty       (tag_empty),
      .count       (outstanding_out)
   );

   always_ff @(posedge clk or posedge preset_full) begin
      if (preset_full) begin
         credit_return_out <= 1'b0;
         err_orphan_out    <= 1'b0;
      end else begin
         credit_return_out <= depart;
         if (rsp_valid_in && tag_empty) err_orphan_out <= 1'b1;
      end
   end

`ifdef TM_SLAVE_RSP_SKID_EN
   logic [1:0]                occ;
   logic [WIDTH_TAG-1:0]      e0_tag, e1_tag;
   logic [WIDTH_DATA_OUT-1:0] e0_data, e1_data;

   // Ready depends only on registered occupancy, cutting the rsp_ready_in path.
   assign rsp_ready_out = ~tag_empty & (occ != 2'd2);
   assign rsp_valid_out = (occ != 2'd0);
   assign rsp_tag_out   = e0_tag;
   assign rsp_data_out  = e0_data;

   always_ff @(posedge clk or posedge preset_full) begin
      if (preset_full) begin
         occ     <= '0;
         e0_tag  <= '0;
         e0_data <= '0;
         e1_tag  <= '0;
         e1_data <= '0;
      end else begin
         case ({pop, depart})
            2'b01: begin
               e0_tag  <= e1_tag;
               e0_data <= e1_data;
               occ     <= occ - 2'd1;
            end
            2'b10: begin
               if (occ == 2'd0) begin
                  e0_tag  <= tag_head;
                  e0_data <= rsp_data_in;
               end else begin
                  e1_tag  <= tag_head;
                  e1_data <= rsp_data_in;
               end
               occ <= occ + 2'd1;
            end
            // Departure plus accept can only occur with one entry held.
            2'b11: begin
               e0_tag  <= tag_head;
               e0_data <= rsp_data_in;
            end
            default: ;
         endcase
      end
   end
`else
   logic out_slot_free;

   assign out_slot_free = ~rsp_valid_out | rsp_ready_in;
   assign rsp_ready_out = ~tag_empty & out_slot_free;

   always_ff @(posedge clk or posedge preset_full) begin
      if (preset_full) begin
         rsp_valid_out <= 1'b0;
         rsp_tag_out   <= '0;
         rsp_data_out  <= '0;
      end else if (pop) begin
         rsp_valid_out <= 1'b1;
         rsp_tag_out   <= tag_head;
         rsp_data_out  <= rsp_data_in;
      end else if (rsp_ready_in) begin
         rsp_valid_out <= 1'b0;
      end
   end
`endif

endmodule

// File: tb/tb_tm_slave_multimaster_rb.sv
// Randomized bench for tm_slave_multimaster_rb against a queue-based reference model.
// Honours TM_SLAVE_RSP_SKID_EN to select the expected output-stage capacity.
module tb_tm_slave_multimaster_rb;

   localparam int WDI = 36;
   localparam int WDO = 36;
   localparam int WT  = 8;
   localparam int MAX = 8;

   logic           clk = 1'b0;
   logic           preset_full;
   logic           req_valid_in, req_ready_in, rsp_valid_in, rsp_ready_in;
   logic [WT-1:0]  req_tag_in;
   logic [WDI-1:0] req_data_in;
   logic [WDO-1:0] rsp_data_in;
   logic           req_ready_out, req_valid_out, rsp_ready_out, rsp_valid_out;
   logic [WDI-1:0] req_data_out;
   logic [WT-1:0]  rsp_tag_out;
   logic [WDO-1:0] rsp_data_out;
   logic           credit_return_out, err_orphan_out;
   logic [3:0]     outstanding_out;

   int unsigned n_cmp = 0;
   int unsigned n_bad = 0;

   logic [WT-1:0]       tagq [$];
   logic [WT+WDO-1:0]   outq [$];
   bit                  credit_m;
   bit                  err_m;

   always #5 clk = ~clk;

   tm_slave_multimaster_rb #(
      .WIDTH_DATA_IN   (WDI),
      .WIDTH_DATA_OUT  (WDO),
      .WIDTH_TAG       (WT),
      .MAX_OUTSTANDING (MAX)
   ) dut (
      .clk               (clk),
      .preset_full       (preset_full),
      .req_valid_in      (req_valid_in),
      .req_ready_out     (req_ready_out),
      .req_tag_in        (req_tag_in),
      .req_data_in       (req_data_in),
      .req_valid_out     (req_valid_out),
      .req_ready_in      (req_ready_in),
      .req_data_out      (req_data_out),
      .rsp_valid_in      (rsp_valid_in),
      .rsp_ready_out     (rsp_ready_out),
      .rsp_data_in       (rsp_data_in),
      .rsp_valid_out     (rsp_valid_out),
      .rsp_ready_in      (rsp_ready_in),
      .rsp_tag_out       (rsp_tag_out),
      .rsp_data_out      (rsp_data_out),
      .credit_return_out (credit_return_out),
      .outstanding_out   (outstanding_out),
      .err_orphan_out    (err_orphan_out)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [WDO-1:0] rand_data();
      logic [63:0] r;
      r = {$urandom(), $urandom()};
      return r[WDO-1:0];
   endfunction

   task automatic check_reset_outputs();
      check("rst_rsp_valid", 64'(rsp_valid_out), 64'd0);
      check("rst_rsp_ready", 64'(rsp_ready_out), 64'd0);
      check("rst_credit", 64'(credit_return_out), 64'd0);
      check("rst_outstanding", 64'(outstanding_out), 64'd0);
      check("rst_err", 64'(err_orphan_out), 64'd0);
      check("rst_tag", 64'(rsp_tag_out), 64'd0);
      check("rst_data", 64'(rsp_data_out), 64'd0);
   endtask

   // Asynchronous reset asserted at a negedge, checked before any clock edge.
   task automatic do_reset();
      @(negedge clk);
      req_valid_in = 1'b0; rsp_valid_in = 1'b0;
      req_ready_in = 1'b0; rsp_ready_in = 1'b0;
      preset_full  = 1'b1;
      #1;
      check_reset_outputs();
      tagq.delete(); outq.delete();
      credit_m = 1'b0; err_m = 1'b0;
      @(negedge clk);
      preset_full = 1'b0;
   endtask

   // One clock of stimulus: compare DUT against model, then advance the model.
   task automatic step(input bit rv, input logic [WT-1:0] t, input bit mr,
                       input bit pv, input logic [WDO-1:0] pd, input bit rdy);
      int unsigned nt;
      bit full, e_rrdy, e_sprdy, depart, pop, push;
      logic [WDI-1:0] qd;
      @(negedge clk);
      qd = rand_data();
      req_valid_in = rv; req_tag_in = t; req_ready_in = mr; req_data_in = qd;
      rsp_valid_in = pv; rsp_data_in = pd; rsp_ready_in = rdy;
      #1;
      nt     = tagq.size();
      full   = (nt == MAX);
      e_rrdy = mr && !full;
`ifdef TM_SLAVE_RSP_SKID_EN
      e_sprdy = (nt != 0) && (outq.size() < 2);
`else
      e_sprdy = (nt != 0) && (outq.size() == 0 || rdy);
`endif
      check("req_valid_out", 64'(req_valid_out), 64'(rv && !full));
      check("req_ready_out", 64'(req_ready_out), 64'(e_rrdy));
      check("req_data_out", 64'(req_data_out), 64'(qd));
      check("rsp_ready_out", 64'(rsp_ready_out), 64'(e_sprdy));
      check("rsp_valid_out", 64'(rsp_valid_out), 64'(outq.size() != 0));
      if (outq.size() != 0) begin
         check("rsp_tag_out", 64'(rsp_tag_out), 64'(outq[0][WT+WDO-1:WDO]));
         check("rsp_data_out", 64'(rsp_data_out), 64'(outq[0][WDO-1:0]));
      end
      check("credit", 64'(credit_return_out), 64'(credit_m));
      check("outstanding", 64'(outstanding_out), 64'(nt));
      check("err_orphan", 64'(err_orphan_out), 64'(err_m));
      @(posedge clk);
      depart = (outq.size() != 0) && rdy;
      pop    = pv && e_sprdy;
      push   = rv && e_rrdy;
      if (pv && nt == 0) err_m = 1'b1;
      credit_m = depart;
      if (depart) void'(outq.pop_front());
      if (pop)    outq.push_back({tagq.pop_front(), pd});
      if (push)   tagq.push_back(t);
   endtask

   task automatic rand_phase(input int cycles, input int p_req, input int p_mr,
                             input int p_rsp, input int p_rdy);
      for (int i = 0; i < cycles; i++) begin
         step($urandom_range(99) < p_req, WT'($urandom()), $urandom_range(99) < p_mr,
              $urandom_range(99) < p_rsp, rand_data(), $urandom_range(99) < p_rdy);
      end
   endtask

   initial begin
      preset_full = 1'b0;
      req_valid_in = 1'b0; req_ready_in = 1'b0; req_tag_in = '0; req_data_in = '0;
      rsp_valid_in = 1'b0; rsp_ready_in = 1'b0; rsp_data_in = '0;
      credit_m = 1'b0; err_m = 1'b0;

      // Single transaction: tag 0x11 out, response 0xABC back.
      do_reset();
      step(1, 8'h11, 1, 0, '0, 1);
      step(0, 8'h00, 1, 0, '0, 1);
      step(0, 8'h00, 1, 1, 36'hABC, 1);
      for (int i = 0; i < 3; i++) step(0, 8'h00, 1, 0, '0, 1);

      // Fill to capacity with the module held off, then drain in order.
      do_reset();
      for (int i = 0; i < 10; i++) step(1, WT'(i), 1, 0, '0, 1);
      for (int i = 0; i < 12; i++) step(0, 8'h00, 1, 1, rand_data(), 1);

      // Packetizer stalled for 5 cycles, then released.
      for (int i = 0; i < 4; i++) step(1, WT'(8'h40 + i), 1, 0, '0, 1);
      for (int i = 0; i < 5; i++) step(0, 8'h00, 1, 1, rand_data(), 0);
      for (int i = 0; i < 6; i++) step(0, 8'h00, 1, 1, rand_data(), 1);

      // Orphan response: sticky error until reset.
      do_reset();
      step(0, 8'h00, 1, 1, rand_data(), 1);
      for (int i = 0; i < 4; i++) step(1, WT'(i), 1, 0, '0, 1);
      for (int i = 0; i < 4; i++) step(0, 8'h00, 1, 1, rand_data(), 1);

      // Streaming at depth 7: push and pop every cycle.
      do_reset();
      for (int i = 0; i < 7; i++) step(1, WT'(i), 1, 0, '0, 1);
      for (int i = 7; i < 30; i++) step(1, WT'(i), 1, 1, rand_data(), 1);
      for (int i = 0; i < 10; i++) step(0, 8'h00, 1, 1, rand_data(), 1);

      // Random traffic under several load mixes.
      do_reset();
      rand_phase(600, 60, 80, 60, 70);
      rand_phase(400, 90, 90, 20, 90);
      rand_phase(400, 30, 70, 90, 40);
      rand_phase(400, 80, 60, 80, 90);

      // Reset mid-transfer: 3 tags held and a response waiting.
      do_reset();
      for (int i = 0; i < 4; i++) step(1, WT'(8'h20 + i), 1, 0, '0, 1);
      step(0, 8'h00, 1, 1, rand_data(), 0);
      step(0, 8'h00, 1, 0, '0, 0);
      do_reset();
      step(1, 8'h5A, 1, 0, '0, 1);
      step(0, 8'h00, 1, 1, 36'h123, 0);
      for (int i = 0; i < 3; i++) step(0, 8'h00, 1, 0, '0, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
